// File: rtl/pong_match_ctrl_pkg.sv
// Shared Pong definitions: board geometry, match FSM encodings and winner codes.
package pong_match_ctrl_pkg;

  localparam int GAME_WIDTH_TILES    = 40;
  localparam int GAME_HEIGHT_TILES   = 30;
  localparam int PADDLE_HEIGHT_TILES = 6;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SERVE      = 3'd1;
  localparam logic [2:0] ST_RUNNING    = 3'd2;
  localparam logic [2:0] ST_POINT_P1   = 3'd3;
  localparam logic [2:0] ST_POINT_P2   = 3'd4;
  localparam logic [2:0] ST_MATCH_OVER = 3'd5;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/pong_miss_detect.sv
// Flags a miss when the ball sits in a paddle's column but outside the rows it covers.
module pong_miss_detect #(
  parameter int c_X_W           = 6,
  parameter int c_Y_W           = 5,
  parameter int c_PADDLE_HEIGHT = 6
) (
  input  logic [c_X_W-1:0] i_Ball_X,
  input  logic [c_Y_W-1:0] i_Ball_Y,
  input  logic [c_Y_W-1:0] i_Paddle_Y,
  input  logic [c_X_W-1:0] i_Paddle_Col,
  output logic             o_Miss
);

  // One extra bit keeps the paddle bottom row from wrapping near the board edge.
  localparam logic [c_Y_W:0] c_SPAN = (c_Y_W+1)'(c_PADDLE_HEIGHT - 1);

  logic [c_Y_W:0] w_Ball_Y;
  logic [c_Y_W:0] w_Top;
  logic [c_Y_W:0] w_Bottom;

  assign w_Ball_Y = {1'b0, i_Ball_Y};
  assign w_Top    = {1'b0, i_Paddle_Y};
  assign w_Bottom = w_Top + c_SPAN;

  assign o_Miss = (i_Ball_X == i_Paddle_Col) && ((w_Ball_Y < w_Top) || (w_Ball_Y > w_Bottom));

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve delay, miss detection, scoring and winner declaration.
module pong_match_ctrl
  import pong_match_ctrl_pkg::*;
#(
  parameter int c_GAME_WIDTH    = GAME_WIDTH_TILES,
  parameter int c_GAME_HEIGHT   = GAME_HEIGHT_TILES,
  parameter int c_PADDLE_HEIGHT = PADDLE_HEIGHT_TILES,
  parameter int c_PADDLE_COL_P1 = 0,
  parameter int c_PADDLE_COL_P2 = c_GAME_WIDTH - 1,
  parameter int c_SCORE_LIMIT   = 9,
  parameter int c_SERVE_DELAY   = 25000000
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic                             i_Game_Start,
  input  logic [$clog2(c_GAME_WIDTH)-1:0]  i_Ball_X,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_Ball_Y,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_Paddle_Y_P1,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_Paddle_Y_P2,
  output logic                             o_Game_Active,
  output logic                             o_Ball_Reset,
  output logic                             o_Serve_Dir,
  output logic [3:0]                       o_P1_Score,
  output logic [3:0]                       o_P2_Score,
  output logic [1:0]                       o_Winner,
  output logic [2:0]                       o_State
);

  localparam int c_X_W   = $clog2(c_GAME_WIDTH);
  localparam int c_Y_W   = $clog2(c_GAME_HEIGHT);
  localparam int c_CNT_W = (c_SERVE_DELAY > 1) ? $clog2(c_SERVE_DELAY) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_SERVE_DELAY - 1);
  localparam logic [3:0]         c_LIMIT    = 4'(c_SCORE_LIMIT);

  logic [2:0]         r_State;
  logic [c_CNT_W-1:0] r_Cnt;
  logic [3:0]         r_P1_Score;
  logic [3:0]         r_P2_Score;
  logic [1:0]         r_Winner;
  logic               r_Serve_Dir;
  logic               r_Start_d;

  logic       w_Start_Evt;
  logic       w_Miss_P1;
  logic       w_Miss_P2;
  logic [3:0] w_P1_Inc;
  logic [3:0] w_P2_Inc;

  assign w_Start_Evt = i_Game_Start & ~r_Start_d;
  assign w_P1_Inc    = (r_P1_Score < c_LIMIT) ? r_P1_Score + 4'd1 : r_P1_Score;
  assign w_P2_Inc    = (r_P2_Score < c_LIMIT) ? r_P2_Score + 4'd1 : r_P2_Score;

  pong_miss_detect #(
    .c_X_W          (c_X_W),
    .c_Y_W          (c_Y_W),
    .c_PADDLE_HEIGHT(c_PADDLE_HEIGHT)
  ) u_miss_p1 (
    .i_Ball_X    (i_Ball_X),
    .i_Ball_Y    (i_Ball_Y),
    .i_Paddle_Y  (i_Paddle_Y_P1),
    .i_Paddle_Col(c_X_W'(c_PADDLE_COL_P1)),
    .o_Miss      (w_Miss_P1)
  );

  pong_miss_detect #(
    .c_X_W          (c_X_W),
    .c_Y_W          (c_Y_W),
    .c_PADDLE_HEIGHT(c_PADDLE_HEIGHT)
  ) u_miss_p2 (
    .i_Ball_X    (i_Ball_X),
    .i_Ball_Y    (i_Ball_Y),
    .i_Paddle_Y  (i_Paddle_Y_P2),
    .i_Paddle_Col(c_X_W'(c_PADDLE_COL_P2)),
    .o_Miss      (w_Miss_P2)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State     <= ST_IDLE;
      r_Cnt       <= '0;
      r_P1_Score  <= 4'd0;
      r_P2_Score  <= 4'd0;
      r_Winner    <= WIN_NONE;
      r_Serve_Dir <= 1'b1;
      r_Start_d   <= 1'b0;
    end else begin
      r_Start_d <= i_Game_Start;
      case (r_State)
        ST_IDLE: begin
          if (w_Start_Evt) begin
            r_State <= ST_SERVE;
            r_Cnt   <= '0;
          end
        end
        ST_SERVE: begin
          if (r_Cnt == c_CNT_LAST) r_State <= ST_RUNNING;
          else                     r_Cnt   <= r_Cnt + 1'b1;
        end
        ST_RUNNING: begin
          // P1's miss wins a tie so a degenerate one-column board stays deterministic.
          if (w_Miss_P1)      r_State <= ST_POINT_P2;
          else if (w_Miss_P2) r_State <= ST_POINT_P1;
        end
        ST_POINT_P1: begin
          r_P1_Score  <= w_P1_Inc;
          r_Serve_Dir <= 1'b0;
          r_Cnt       <= '0;
          if (w_P1_Inc == c_LIMIT) begin
            r_State  <= ST_MATCH_OVER;
            r_Winner <= WIN_P1;
          end else begin
            r_State <= ST_SERVE;
          end
        end
        ST_POINT_P2: begin
          r_P2_Score  <= w_P2_Inc;
          r_Serve_Dir <= 1'b1;
          r_Cnt       <= '0;
          if (w_P2_Inc == c_LIMIT) begin
            r_State  <= ST_MATCH_OVER;
            r_Winner <= WIN_P2;
          end else begin
            r_State <= ST_SERVE;
          end
        end
        ST_MATCH_OVER: begin
          if (w_Start_Evt) begin
            r_P1_Score  <= 4'd0;
            r_P2_Score  <= 4'd0;
            r_Winner    <= WIN_NONE;
            r_Serve_Dir <= 1'b1;
            r_Cnt       <= '0;
            r_State     <= ST_SERVE;
          end
        end
        default: r_State <= ST_IDLE;
      endcase
    end
  end

  assign o_Game_Active = (r_State == ST_RUNNING);
  assign o_Ball_Reset  = (r_State != ST_RUNNING);
  assign o_Serve_Dir   = r_Serve_Dir;
  assign o_P1_Score    = r_P1_Score;
  assign o_P2_Score    = r_P2_Score;
  assign o_Winner      = r_Winner;
  assign o_State       = r_State;

endmodule
